btn_ctrl: RTL

Parametrised memory-mapped push-button controller, successor to the two-button `btn` peripheral. It serves NUM_BTNS inputs, and each channel has a synchroniser and a debouncer. Press and release events are held in sticky registers that clear on read or by write-1-to-clear. A maskable interrupt line is driven from the sticky press bits. The block sits on the CPU data bus beside the other peripherals and uses the same read_enable/address/data_out convention as `btn`.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 71 +++++++
 rtl/btn_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the btn_ctrl push-button controller.
//   - Byte offsets of the four bus-visible registers.
//   - Register-select enum produced by the address decoder.
package btn_pkg;

  localparam int BTN_DATA_W = 32;

  localparam int BTN_PRESSED_OFF  = 'h00;
  localparam int BTN_RELEASED_OFF = 'h04;
  localparam int BTN_LEVEL_OFF    = 'h08;
  localparam int BTN_IRQ_EN_OFF   = 'h0C;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PRESSED,
    SEL_RELEASED,
    SEL_LEVEL,
    SEL_IRQ_EN
  } btn_sel_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel.
//   Optional inversion, 2-flop synchroniser, stability counter, debounced flop.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   btn_raw_i     raw asynchronous pin
//   level_o       debounced level (registered)
//   rise_o        1 on the cycle whose edge takes level 0->1 (combinational)
//   fall_o        1 on the cycle whose edge takes level 1->0 (combinational)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             raw;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  assign raw = (ACTIVE_LOW != 0) ? ~btn_raw_i : btn_raw_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; a blocking assignment here would collapse the two
  // synchroniser stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // The counter only advances while the synchronised input disagrees with the
  // accepted level; once it has counted DEBOUNCE_CYCLES disagreeing cycles,
  // one more disagreeing cycle flips the level.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pulses are taken from the next state so the sticky bits in the parent set
  // on the same edge that the level changes.
  assign rise_o  =  level_d & ~level_q;
  assign fall_o  = ~level_d &  level_q;
  assign level_o =  level_q;

endmodule

// File: rtl/btn_ctrl.sv
// btn_ctrl: memory-mapped push-button controller.
//   NUM_BTNS debounced channels, sticky PRESSED/RELEASED registers (clear on
//   read, write-1-to-clear), LEVEL register, IRQ_EN mask and a registered
//   level interrupt.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   btn            raw button pins
//   read_enable    bus read strobe (wins over write_enable)
//   write_enable   bus write strobe
//   address        register byte address
//   data_in        write data
//   data_out       registered read data, held until the next read
//   irq            registered OR of (PRESSED & IRQ_EN)
module btn_ctrl
  import btn_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BTNS-1:0]   btn,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [BTN_DATA_W-1:0] data_in,
  output logic [BTN_DATA_W-1:0] data_out,
  output logic                  irq
);

  logic [NUM_BTNS-1:0]   level, rise, fall;
  logic [NUM_BTNS-1:0]   pressed_q, pressed_d;
  logic [NUM_BTNS-1:0]   released_q, released_d;
  logic [NUM_BTNS-1:0]   irq_en_q, irq_en_d;
  logic [NUM_BTNS-1:0]   clr_pressed, clr_released;
  logic [BTN_DATA_W-1:0] data_out_q, data_out_d, rd_data;
  logic                  irq_q;
  logic                  rd, wr;
  btn_sel_e              sel;

  // Bits of data_in above NUM_BTNS are ignored by design.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw_i(btn[i]),
      .level_o  (level[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  always_comb begin
    sel = SEL_NONE;
    if      (address == ADDR_WIDTH'(BTN_PRESSED_OFF))  sel = SEL_PRESSED;
    else if (address == ADDR_WIDTH'(BTN_RELEASED_OFF)) sel = SEL_RELEASED;
    else if (address == ADDR_WIDTH'(BTN_LEVEL_OFF))    sel = SEL_LEVEL;
    else if (address == ADDR_WIDTH'(BTN_IRQ_EN_OFF))   sel = SEL_IRQ_EN;
  end

  // A simultaneous read and write performs only the read.
  assign rd = read_enable;
  assign wr = write_enable & ~read_enable;

  always_comb begin
    rd_data      = '0;
    clr_pressed  = '0;
    clr_released = '0;
    irq_en_d     = irq_en_q;

    case (sel)
      SEL_PRESSED:  rd_data[NUM_BTNS-1:0] = pressed_q;
      SEL_RELEASED: rd_data[NUM_BTNS-1:0] = released_q;
      SEL_LEVEL:    rd_data[NUM_BTNS-1:0] = level;
      SEL_IRQ_EN:   rd_data[NUM_BTNS-1:0] = irq_en_q;
      default:      rd_data = '0;
    endcase

    // Clear-on-read removes exactly the bits being returned.
    if (rd && sel == SEL_PRESSED)  clr_pressed  = pressed_q;
    if (rd && sel == SEL_RELEASED) clr_released = released_q;
    if (wr && sel == SEL_PRESSED)  clr_pressed  = data_in[NUM_BTNS-1:0];
    if (wr && sel == SEL_RELEASED) clr_released = data_in[NUM_BTNS-1:0];
    if (wr && sel == SEL_IRQ_EN)   irq_en_d     = data_in[NUM_BTNS-1:0];

    // An event arriving on the clearing edge survives the clear.
    pressed_d  = (pressed_q  & ~clr_pressed)  | rise;
    released_d = (released_q & ~clr_released) | fall;

    data_out_d = rd ? rd_data : data_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_q  <= '0;
      released_q <= '0;
      irq_en_q   <= '0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pressed_q  <= pressed_d;
      released_q <= released_d;
      irq_en_q   <= irq_en_d;
      data_out_q <= data_out_d;
      irq_q      <= |(pressed_q & irq_en_q);
    end
  end

  assign data_out = data_out_q;
  assign irq      = irq_q;

endmodule
